// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control FSM for the RV32 subset datapath (lh, sh, R-type, andi, slli, bne)
//
// Sequences each instruction through BUSCA, DECODIFICA, EXECUTA, MEMORIA and
// ESCRITA over a shared ALU and a single memory port.
//
// Optional feature macro: MEM_ESPERA_EN
//   defined   : BUSCA and MEMORIA hold until mem_pronto=1
//   undefined : mem_pronto is ignored, every memory state lasts one cycle
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   inicio              run enable, sampled in OCIOSO and on retire
//   opcode/funct3/funct7 instruction register fields (funct7 unused here)
//   zero                ALU zero flag, used only in EXECUTA
//   mem_pronto          memory access completes this cycle
//   pc_escrita, ir_escrita, pc_desvio, ALUop, ALUSrc,
//   sinal_leitura, sinal_escrita, reg_escrita, MemToReg
//                       datapath controls
//   instr_invalida      sticky illegal-opcode flag
//   estado              current state encoding
//   instr_contador      retired-instruction counter, wraps modulo 2^CONT_W

module controle_multiciclo #(
    parameter int CONT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inicio,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic              zero,
    input  logic              mem_pronto,
    output logic              pc_escrita,
    output logic              ir_escrita,
    output logic              pc_desvio,
    output logic [1:0]        ALUop,
    output logic              ALUSrc,
    output logic              sinal_leitura,
    output logic              sinal_escrita,
    output logic              reg_escrita,
    output logic              MemToReg,
    output logic              instr_invalida,
    output logic [2:0]        estado,
    output logic [CONT_W-1:0] instr_contador
);

    localparam logic [2:0] OCIOSO     = 3'd0;
    localparam logic [2:0] BUSCA      = 3'd1;
    localparam logic [2:0] DECODIFICA = 3'd2;
    localparam logic [2:0] EXECUTA    = 3'd3;
    localparam logic [2:0] MEMORIA    = 3'd4;
    localparam logic [2:0] ESCRITA    = 3'd5;
    localparam logic [2:0] ERRO       = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic pronto;
`ifdef MEM_ESPERA_EN
    assign pronto = mem_pronto;
    logic unused_campos;
    assign unused_campos = ^funct7;
`else
    assign pronto = 1'b1;
    logic unused_campos;
    assign unused_campos = ^{funct7, mem_pronto};
`endif

    logic is_load, is_store, is_rtype, is_itype, is_branch, op_valida;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_branch = (opcode == OP_BRANCH);
    assign op_valida = is_load | is_store | is_rtype | is_itype | is_branch;

    logic [2:0] prox;
    logic       retira;
    logic       marca_invalida;
    logic       invalida_q;

    assign instr_invalida = invalida_q;

    always_comb begin
        pc_escrita     = 1'b0;
        ir_escrita     = 1'b0;
        pc_desvio      = 1'b0;
        ALUop          = 2'b00;
        ALUSrc         = 1'b0;
        sinal_leitura  = 1'b0;
        sinal_escrita  = 1'b0;
        reg_escrita    = 1'b0;
        MemToReg       = 1'b0;
        prox           = estado;
        retira         = 1'b0;
        marca_invalida = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) prox = BUSCA;
            end
            BUSCA: begin
                sinal_leitura = 1'b1;
                if (pronto) begin
                    ir_escrita = 1'b1;
                    pc_escrita = 1'b1;
                    prox       = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (op_valida) begin
                    prox = EXECUTA;
                end else begin
                    prox           = ERRO;
                    marca_invalida = 1'b1;
                end
            end
            EXECUTA: begin
                if (is_load || is_store) begin
                    ALUop  = 2'b00;
                    ALUSrc = 1'b1;
                    prox   = MEMORIA;
                end else if (is_rtype) begin
                    ALUop = 2'b10;
                    prox  = ESCRITA;
                end else if (is_itype) begin
                    ALUSrc = 1'b1;
                    case (funct3)
                        3'b111:  ALUop = 2'b11;
                        3'b001:  ALUop = 2'b10;
                        default: ALUop = 2'b00;
                    endcase
                    prox = ESCRITA;
                end else if (is_branch) begin
                    // bne: take the branch target only when operands differ
                    ALUop      = 2'b01;
                    pc_desvio  = 1'b1;
                    pc_escrita = ~zero;
                    retira     = 1'b1;
                end else begin
                    // opcode changed under us after decode; treat as illegal
                    prox = ERRO;
                end
            end
            MEMORIA: begin
                ALUop         = 2'b00;
                ALUSrc        = 1'b1;
                sinal_leitura = is_load;
                sinal_escrita = is_store;
                if (pronto) begin
                    if (is_load) prox = ESCRITA;
                    else         retira = 1'b1;
                end
            end
            ESCRITA: begin
                reg_escrita = 1'b1;
                MemToReg    = is_load;
                retira      = 1'b1;
            end
            ERRO: begin
                prox = ERRO;
            end
            default: begin
                prox = ERRO;
            end
        endcase
        if (retira) prox = inicio ? BUSCA : OCIOSO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            instr_contador <= '0;
            invalida_q     <= 1'b0;
        end else begin
            estado <= prox;
            if (retira) instr_contador <= instr_contador + {{(CONT_W-1){1'b0}}, 1'b1};
            if (marca_invalida) invalida_q <= 1'b1;
        end
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control FSM for the RV32 subset datapath (lh, sh, R-type, andi, slli, bne). It sequences each instruction through the fetch, decode, execute, memory and writeback steps over a shared ALU and a single memory port, and drives the same control signal set as the single-cycle decoder plus PC/IR write enables. It sits between the instruction register (opcode/funct fields), the ALU zero flag and the memory ready line on one side, and the multicycle datapath muxes and enables on the other.

## Interface
- CONT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inicio  in  1  run enable; leaving OCIOSO and continuing after retire require 1
- opcode  in  7  IR[6:0]; stable from DECODIFICA until the next BUSCA
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]; no effect on control outputs in this subset
- zero  in  1  ALU zero flag; sampled only in EXECUTA
- mem_pronto  in  1  memory access completes this cycle
- pc_escrita  out  1  PC write enable
- ir_escrita  out  1  IR write enable
- pc_desvio  out  1  PC source = branch target (else PC+4)
- ALUop  out  2  ALU control class
- ALUSrc  out  1  ALU operand B = immediate
- sinal_leitura / sinal_escrita  out  1 each  memory read / write strobe
- reg_escrita  out  1  register file write enable
- MemToReg  out  1  writeback source = memory
- instr_invalida  out  1  sticky illegal-opcode flag
- estado  out  3  current state encoding
- instr_contador  out  CONT_W  retired instructions, wraps modulo 2^CONT_W

## Operation
- State encodings: OCIOSO=0, BUSCA=1, DECODIFICA=2, EXECUTA=3, MEMORIA=4, ESCRITA=5, ERRO=6. Encoding 7 is unreachable and goes to ERRO.
- Outputs are combinational from the state, opcode, funct3 and zero. An output not listed for a state is 0.
- OCIOSO: all outputs are 0. The FSM goes to BUSCA when inicio=1.
- BUSCA: sinal_leitura=1. When mem_pronto=1, ir_escrita=1 and pc_escrita=1 (PC+4), then the FSM goes to DECODIFICA. Otherwise it holds in BUSCA.
- DECODIFICA: no outputs. Opcodes 0000011, 0100011, 0110011, 0010011 and 1100011 go to EXECUTA. Any other opcode goes to ERRO and sets instr_invalida.
- EXECUTA drives ALUop/ALUSrc as follows:
  - load and store: 00/1
  - R-type: 10/0
  - I-type with funct3 111: 11/1; funct3 001: 10/1; any other funct3: 00/1
  - bne: 01/0, with pc_desvio=1 and pc_escrita=~zero
- EXECUTA next state: bne retires; load and store go to MEMORIA; R-type and I-type go to ESCRITA.
- MEMORIA: ALUop=00 and ALUSrc=1 are held. A load drives sinal_leitura=1; a store drives sinal_escrita=1. The FSM holds until mem_pronto=1. Then a store retires and a load goes to ESCRITA.
- ESCRITA: reg_escrita=1. MemToReg=1 only for a load. Then the instruction retires.
- Retire:
  - instr_contador increments by 1 on the same edge.
  - The next state is BUSCA if inicio=1, otherwise OCIOSO.
  - All-ones wraps to 0.
- ERRO: absorbing state; all outputs 0 except instr_invalida=1. Only rst_n exits it.

## Timing
- Reset (rst_n low, asynchronous): estado=OCIOSO, instr_contador=0, instr_invalida=0, and all strobes read 0 immediately.
- Reset release is synchronous to the first clk edge with rst_n=1.
- Reset mid-instruction: the FSM aborts to OCIOSO and no partial retire is counted.
- Cycles per instruction with mem_pronto held at 1: bne 3, R-type/I-type 4, sh 4, lh 5.
- Each cycle with mem_pronto=0 in BUSCA or MEMORIA adds 1 cycle. Strobes stay asserted and unchanged while waiting.
- The branch decision uses zero in the EXECUTA cycle only.
- inicio is sampled only in OCIOSO and on retire edges. Dropping it mid-instruction does not abort the instruction.

## Configuration
- MEM_ESPERA_EN defined: BUSCA and MEMORIA wait on mem_pronto as described.
- MEM_ESPERA_EN undefined: mem_pronto is ignored and treated as 1, so every memory state lasts exactly 1 cycle.

## Test plan
- Reset then inicio=1 with add (opcode 0110011), mem_pronto=1: estado 0→1→2→3→5→1. ALUop=10 and ALUSrc=0 in EXECUTA, reg_escrita=1 in ESCRITA, instr_contador=1.
- lh with mem_pronto low for 2 cycles in MEMORIA: sinal_leitura held 3 cycles, then ESCRITA with MemToReg=1. Total 7 cycles.
- bne with zero=0, then bne with zero=1: pc_escrita=1 with pc_desvio=1 in the first EXECUTA, pc_escrita=0 in the second. Each takes 3 cycles, and no reg_escrita is asserted.
- sh followed by andi (funct3 111): sinal_escrita=1 for 1 MEMORIA cycle with no ESCRITA. Then ALUop=11 and ALUSrc=1 for andi.
- Opcode 1101111 in DECODIFICA: estado=6 with instr_invalida=1 held for 10 cycles regardless of inicio. rst_n pulse clears both to 0.
- inicio=0 during ESCRITA: retire goes to OCIOSO. Preload instr_contador to all-ones and retire: it wraps to 0.
